lfo_envelope: RTL and testbench
===============================

LFO_ENVELOPE -- requirements
Module: lfo_envelope

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 CLK  in  1  single system clock; all state updates on posedge CLK.
REQ-003 RES  in  1  reset, asynchronous, active-high.
REQ-004 ACLK_EN  in  1  APU-cycle enable, one CLK-wide pulse per APU cycle.
REQ-005 nLFO1  in  1  quarter-frame strobe, inverse polarity (0: LFO triggers), sampled only when ACLK_EN=1.
REQ-006 WR_REG  in  1  control register write strobe, one CLK wide, not gated by ACLK_EN.
REQ-007 WR_RESTART  in  1  length-register write strobe, one CLK wide; requests envelope restart.
REQ-008 DIN  in  8  write data: bit5 LOOP, bit4 CONST, bits3:0 VOL (volume or divider period).
REQ-009 ENV_OUT  out  4  envelope volume.
REQ-010 DECAY_ZERO  out  1  high when decay counter = 0.

Function
REQ-011 SHALL define quarter tick Q = ACLK_EN & ~nLFO1, evaluated per CLK; nLFO1 low for N ACLK_EN pulses SHALL yield N ticks, with no edge detection.
REQ-012 On WR_REG SHALL load loop_r=DIN[5], const_r=DIN[4], vol_r=DIN[3:0].
REQ-013 On WR_RESTART SHALL set start flag; DIN is ignored.
REQ-014 On Q with start=1: start<=0, decay<=15, div<=vol_r.
REQ-015 On Q with start=0, div=0: div<=vol_r; decay<=decay-1 if decay!=0; else decay<=15 if loop_r=1; else decay holds 0.
REQ-016 On Q with start=0, div!=0: div<=div-1; decay holds.
REQ-017 Without Q, div and decay SHALL hold.
REQ-018 div and decay: 4-bit unsigned; arithmetic never wraps except the explicit 0->15 reload in REQ-015.
REQ-019 ENV_OUT = const_r ? vol_r : decay, combinational from registers, no added latency.
REQ-020 DECAY_ZERO = (decay==0), combinational.
REQ-021 Divider period SHALL be vol_r+1 ticks; vol_r=0 SHALL step decay on every tick.
REQ-022 WR_RESTART coincident with Q: Q SHALL act on the pre-write start value; start SHALL end at 1 (set wins over clear).
REQ-023 WR_REG coincident with Q: any div reload in that cycle SHALL use the pre-write vol_r.
REQ-024 WR_REG SHALL NOT alter div, decay or start; new VOL takes effect at next reload.
REQ-025 ACLK_EN=0 SHALL suppress ticks regardless of nLFO1.

Reset
REQ-026 RES=1 SHALL asynchronously clear loop_r, const_r, vol_r, div, decay, start to 0; ENV_OUT=0, DECAY_ZERO=1 while RES held.
REQ-027 Writes and ticks during RES=1 SHALL be ignored; first action possible on the first posedge CLK after RES falls.
REQ-028 RES asserted mid-decay SHALL abort immediately; no restart without a new WR_RESTART.

Verification
REQ-029 Reset: RES pulse mid-sequence with decay=9 -> ENV_OUT=0, DECAY_ZERO=1 within the same cycle, before next CLK edge.
REQ-030 Basic decay: WR_REG DIN=0x02, WR_RESTART, then ticks -> ENV_OUT 15 after tick1, 14 after tick4, 13 after tick7; reaches 0 after tick46 and holds.
REQ-031 Loop: DIN=0x20, WR_RESTART, 17 ticks -> ENV_OUT 15,14,...,0 then 15 on tick17.
REQ-032 Constant: DIN=0x1A, WR_RESTART, 20 ticks -> ENV_OUT=10 throughout; DECAY_ZERO shows internal decay still counting.
REQ-033 Collision: WR_RESTART on same CLK as Q while decay=5, start=0 -> that Q steps div/decay normally; next Q reloads decay=15.
REQ-034 Gating: nLFO1=0 held with ACLK_EN=0 for 100 CLKs -> no change; nLFO1=1 with ACLK_EN pulses -> no change.

Source files
------------

// File: rtl/lfo_envelope.sv
// lfo_envelope: quarter-frame envelope unit with a volume divider, a 4-bit decay
// counter, loop reload and constant-volume override.
module lfo_envelope (
    input  logic       CLK,
    input  logic       RES,
    input  logic       ACLK_EN,
    input  logic       nLFO1,
    input  logic       WR_REG,
    input  logic       WR_RESTART,
    input  logic [7:0] DIN,
    output logic [3:0] ENV_OUT,
    output logic       DECAY_ZERO
);
    logic       loop_r, const_r, start, start_n, q;
    logic [3:0] vol_r, div, decay, div_n, decay_n;
    logic       din_unused;

    assign q          = ACLK_EN & ~nLFO1;
    assign din_unused = ^DIN[7:6];

    // Reloads read the registered vol_r, so a same-cycle WR_REG only affects later reloads.
    always_comb begin
        div_n   = !q ? div : (start || div == 4'd0) ? vol_r : div - 4'd1;
        decay_n = !q ? decay :
                  start ? 4'd15 :
                  div != 4'd0 ? decay :
                  decay != 4'd0 ? decay - 4'd1 :
                  loop_r ? 4'd15 : 4'd0;
        start_n = WR_RESTART | (start & ~q);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            loop_r  <= 1'b0;
            const_r <= 1'b0;
            vol_r   <= 4'd0;
            div     <= 4'd0;
            decay   <= 4'd0;
            start   <= 1'b0;
        end else begin
            if (WR_REG) begin
                loop_r  <= DIN[5];
                const_r <= DIN[4];
                vol_r   <= DIN[3:0];
            end
            div   <= div_n;
            decay <= decay_n;
            start <= start_n;
        end
    end

    assign ENV_OUT    = const_r ? vol_r : decay;
    assign DECAY_ZERO = decay == 4'd0;
endmodule

// File: tb/tb_lfo_envelope.sv
// tb_lfo_envelope: directed vectors; expectations queued by stimulus, checked by a monitor.
module tb_lfo_envelope;
    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       ACLK_EN = 1'b0;
    logic       nLFO1 = 1'b1;
    logic       WR_REG = 1'b0;
    logic       WR_RESTART = 1'b0;
    logic [7:0] DIN = 8'h00;
    logic [3:0] ENV_OUT;
    logic       DECAY_ZERO;

    int vec = 0;
    int errs = 0;

    typedef struct {
        string      name;
        logic [3:0] env;
        logic       dz;
    } exp_t;
    exp_t sb[$];
    event smp;

    lfo_envelope dut (
        .CLK(CLK), .RES(RES), .ACLK_EN(ACLK_EN), .nLFO1(nLFO1), .WR_REG(WR_REG),
        .WR_RESTART(WR_RESTART), .DIN(DIN), .ENV_OUT(ENV_OUT), .DECAY_ZERO(DECAY_ZERO)
    );

    always #5 CLK = ~CLK;

    initial begin
        exp_t e;
        forever begin
            @smp;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                vec++;
                if (ENV_OUT !== e.env || DECAY_ZERO !== e.dz) begin
                    errs++;
                    $display("FAIL %s: got ENV_OUT=%0d DECAY_ZERO=%b, want ENV_OUT=%0d DECAY_ZERO=%b",
                             e.name, ENV_OUT, DECAY_ZERO, e.env, e.dz);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [3:0] env, input logic dz);
        exp_t e;
        e.name = name;
        e.env  = env;
        e.dz   = dz;
        sb.push_back(e);
        ->smp;
    endtask

    task automatic cyc(input logic en, input logic n, input logic wr, input logic rs, input logic [7:0] d);
        ACLK_EN = en; nLFO1 = n; WR_REG = wr; WR_RESTART = rs; DIN = d;
        @(posedge CLK);
        #1;
        ACLK_EN = 1'b0; nLFO1 = 1'b1; WR_REG = 1'b0; WR_RESTART = 1'b0; DIN = 8'h00;
    endtask

    task automatic tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wreg(input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
    endtask

    task automatic restart();
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF);
    endtask

    initial begin
        int e;
        #2 chk("reset_held", 4'd0, 1'b1);
        #10 RES = 1'b0;
        @(posedge CLK); #1;
        chk("after_reset", 4'd0, 1'b1);

        // basic decay: period 3 ticks, no loop
        wreg(8'h02);
        restart();
        chk("restart_pending", 4'd0, 1'b1);
        for (int i = 1; i <= 52; i++) begin
            tick();
            e = (i < 46) ? 15 - (i - 1) / 3 : 0;
            chk($sformatf("decay_t%0d", i), 4'(e), e == 0);
        end

        // loop mode, period 1
        wreg(8'h20);
        restart();
        for (int i = 1; i <= 17; i++) begin
            tick();
            e = (i <= 16) ? 16 - i : 15;
            chk($sformatf("loop_t%0d", i), 4'(e), e == 0);
        end

        // constant volume 10; decay keeps running underneath
        wreg(8'h1A);
        chk("const_write", 4'd10, 1'b0);
        restart();
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk($sformatf("const_t%0d", i), 4'd10, 1'b0);
        end
        wreg(8'h0A);
        chk("const_off_decay14", 4'd14, 1'b0);

        // restart colliding with a tick while decay=5
        wreg(8'h00);
        restart();
        for (int i = 1; i <= 11; i++) tick();
        chk("pre_collide", 4'd5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("collide_step", 4'd4, 1'b0);
        tick();
        chk("collide_reload", 4'd15, 1'b0);
        tick();
        chk("collide_after", 4'd14, 1'b0);

        // register write coinciding with a tick uses old period for that reload
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 8'h03);
        chk("wr_tick", 4'd13, 1'b0);
        tick();
        chk("wr_tick_next", 4'd12, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk($sformatf("newper_hold%0d", i), 4'd12, 1'b0);
        end
        tick();
        chk("newper_step", 4'd11, 1'b0);

        // gating
        for (int i = 1; i <= 100; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            if (i % 25 == 0) chk($sformatf("gate_en0_%0d", i), 4'd11, 1'b0);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
            if (i % 10 == 0) chk($sformatf("gate_n1_%0d", i), 4'd11, 1'b0);
        end

        // async reset mid-decay at 9
        wreg(8'h00);
        restart();
        for (int i = 1; i <= 7; i++) tick();
        chk("pre_reset9", 4'd9, 1'b0);
        #2 RES = 1'b1;
        #1 chk("async_reset", 4'd0, 1'b1);
        #2 RES = 1'b0;
        tick();
        chk("no_auto_restart", 4'd0, 1'b1);

        // writes and ticks while in reset are dropped
        RES = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h1F);
        chk("wr_in_reset", 4'd0, 1'b1);
        #2 RES = 1'b0;
        tick();
        chk("post_reset_tick", 4'd0, 1'b1);

        #1;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
